// File: rtl/qdi_tx_arb_pkg.sv
// Shared definitions for the clocked-to-QDI transmit arbiter: state encoding and
// default geometry of the flit channel.
package qdi_tx_arb_pkg;

  localparam int DW_DEF  = 32;
  localparam int SCN_DEF = DW_DEF / 2;
  localparam int NR_DEF  = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_DATA = 2'd1,
    ST_RTZ  = 2'd2
  } state_t;

endpackage

// File: rtl/qdi_tx_arb_sync2.sv
// Two-flop synchronizer for one asynchronous acknowledge bit.
module sync2 (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta_r;

  // Metastability filter chain
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_r <= 1'b0;
      q      <= 1'b0;
    end else begin
      meta_r <= d;
      q      <= meta_r;
    end
  end

endmodule

// File: rtl/qdi_tx_arb.sv
// Round-robin arbiter with packet lock that serialises clocked flits onto a
// 1-of-4 QDI channel using a four-phase (data / return-to-zero) handshake.
module qdi_tx_arb
  import qdi_tx_arb_pkg::*;
#(
  parameter int DW  = DW_DEF,
  parameter int SCN = DW / 2,
  parameter int NR  = NR_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [NR-1:0]    in_vld,
  input  logic [NR*DW-1:0] in_dat,
  input  logic [NR-1:0]    in_eof,
  output logic [NR-1:0]    in_rdy,
  output logic [SCN-1:0]   o0,
  output logic [SCN-1:0]   o1,
  output logic [SCN-1:0]   o2,
  output logic [SCN-1:0]   o3,
  output logic             o4,
  input  logic [SCN-1:0]   oa,
  output logic             busy
);

  localparam int IW = (NR > 1) ? $clog2(NR) : 1;

  state_t          state_r, state_nxt_s;
  logic            lock_r, eof_r;
  logic [IW-1:0]   owner_r, rr_ptr_r, win_s;
  logic            found_s, accept_s, all_ack_s, no_ack_s;
  logic [SCN-1:0]  ack_s;
  logic [DW-1:0]   win_dat_s;
  logic [SCN-1:0]  r0_s, r1_s, r2_s, r3_s;

  for (genvar i = 0; i < SCN; i++) begin : g_sync
    sync2 u_sync (.clk(clk), .rst_n(rst_n), .d(oa[i]), .q(ack_s[i]));
  end

  assign all_ack_s = &ack_s;
  assign no_ack_s  = ~|ack_s;
  assign accept_s  = (state_r == ST_IDLE) && found_s;
  assign busy      = lock_r | (state_r != ST_IDLE);

  // Winner search: the owner alone while locked, else first valid at/after rr_ptr
  always_comb begin
    int idx;
    idx     = 0;
    found_s = 1'b0;
    win_s   = '0;
    if (lock_r) begin
      found_s = in_vld[owner_r];
      win_s   = owner_r;
    end else begin
      for (int k = 0; k < NR; k++) begin
        idx = (int'(rr_ptr_r) + k) % NR;
        if (!found_s && in_vld[idx]) begin
          found_s = 1'b1;
          win_s   = IW'(idx);
        end
      end
    end
  end

  // Consume strobe; held off while reset is asserted
  always_comb begin
    in_rdy = '0;
    if (accept_s && rst_n) begin
      in_rdy[win_s] = 1'b1;
    end else begin
      in_rdy = '0;
    end
  end

  // 1-of-4 encoding of the winning flit, one dibit per sub-channel
  always_comb begin
    win_dat_s = in_dat[int'(win_s)*DW +: DW];
    r0_s = '0;
    r1_s = '0;
    r2_s = '0;
    r3_s = '0;
    for (int i = 0; i < SCN; i++) begin
      case (win_dat_s[2*i +: 2])
        2'd0:    r0_s[i] = 1'b1;
        2'd1:    r1_s[i] = 1'b1;
        2'd2:    r2_s[i] = 1'b1;
        default: r3_s[i] = 1'b1;
      endcase
    end
  end

  // Handshake sequencing
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: if (accept_s)  state_nxt_s = ST_DATA; else state_nxt_s = ST_IDLE;
      ST_DATA: if (all_ack_s) state_nxt_s = ST_RTZ;  else state_nxt_s = ST_DATA;
      ST_RTZ:  if (no_ack_s)  state_nxt_s = ST_IDLE; else state_nxt_s = ST_RTZ;
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_r <= ST_IDLE;
    else        state_r <= state_nxt_s;
  end

  // Rails, packet lock and round-robin pointer; async reset clears rails at once
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lock_r   <= 1'b0;
      eof_r    <= 1'b0;
      owner_r  <= '0;
      rr_ptr_r <= '0;
      o0 <= '0;
      o1 <= '0;
      o2 <= '0;
      o3 <= '0;
      o4 <= 1'b0;
    end else if (accept_s) begin
      owner_r <= win_s;
      eof_r   <= in_eof[win_s];
      if (!in_eof[win_s]) lock_r <= 1'b1;
      else                lock_r <= lock_r;
      o0 <= r0_s;
      o1 <= r1_s;
      o2 <= r2_s;
      o3 <= r3_s;
      o4 <= in_eof[win_s];
    end else if (state_r == ST_DATA && all_ack_s) begin
      o0 <= '0;
      o1 <= '0;
      o2 <= '0;
      o3 <= '0;
      o4 <= 1'b0;
    end else if (state_r == ST_RTZ && no_ack_s && eof_r) begin
      lock_r <= 1'b0;
      if (owner_r == IW'(NR - 1)) rr_ptr_r <= '0;
      else                        rr_ptr_r <= owner_r + IW'(1);
    end else begin
      lock_r <= lock_r;
    end
  end

endmodule
